// File: rtl/man_mult_radix4.sv
// Sequential radix-4 Booth multiplier: one digit of the multiplicand per cycle,
// terminating early once the remaining multiplicand bits are pure sign extension.
module man_mult_radix4 #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] multiplier_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    output logic             valid_o,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] product_low_o,
    output logic [WIDTH-1:0] product_high_o
);

    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 2;
    localparam int IW = $clog2(WIDTH / 2 + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] mplier;
    logic signed [EW-1:0] mcand;
    logic                 mcand_prev;
    logic                 last;
    logic [IW-1:0]        idx;
    logic [EW-2:0]        rest;
    logic                 term;

    function automatic logic signed [AW-1:0] booth_pp(input logic [2:0]           d,
                                                      input logic signed [AW-1:0] m);
        case (d)
            3'b001, 3'b010: return m;
            3'b011:         return m <<< 1;
            3'b100:         return -(m <<< 1);
            3'b101, 3'b110: return -m;
            default:        return '0;
        endcase
    endfunction

    // mcand is shifted right arithmetically each digit, so bits [EW-1:1] are
    // the not-yet-retired multiplicand bits plus copies of the sign bit.
    assign rest = mcand[EW-1:1];
    assign term = (&rest) | ~(|rest) | (idx == IW'(WIDTH / 2));

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i)        state_next = RUN;
            RUN:     if (last)           state_next = DONE;
            DONE:    if (result_ready_i) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == IDLE);
        valid_o = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            acc            <= '0;
            mplier         <= '0;
            mcand          <= '0;
            mcand_prev     <= 1'b0;
            last           <= 1'b0;
            idx            <= '0;
            product_low_o  <= '0;
            product_high_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mplier     <= {{(AW - WIDTH){signed_i & multiplier_i[WIDTH-1]}}, multiplier_i};
                        mcand      <= {{2{signed_i & multiplicand_i[WIDTH-1]}}, multiplicand_i};
                        mcand_prev <= 1'b0;
                        acc        <= '0;
                        idx        <= '0;
                        last       <= 1'b0;
                    end
                end
                RUN: begin
                    // One extra RUN cycle after the final digit moves the sum to the outputs.
                    if (last) begin
                        product_low_o  <= acc[WIDTH-1:0];
                        product_high_o <= acc[2*WIDTH-1:WIDTH];
                    end else begin
                        acc        <= acc + booth_pp({mcand[1:0], mcand_prev}, mplier);
                        mplier     <= mplier <<< 2;
                        mcand      <= mcand >>> 2;
                        mcand_prev <= mcand[1];
                        idx        <= idx + 1'b1;
                        last       <= term;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_man_mult_radix4.sv
// Scoreboard bench for man_mult_radix4: expected product and latency are queued
// at accept time and compared when valid_o appears.
module tb_man_mult_radix4;

    localparam int W = 28;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           start_i;
    logic           ready_o;
    logic           signed_i;
    logic [W-1:0]   multiplier_i;
    logic [W-1:0]   multiplicand_i;
    logic           valid_o;
    logic           result_ready_i;
    logic [W-1:0]   product_low_o;
    logic [W-1:0]   product_high_o;

    int             errors = 0;
    int             checks = 0;
    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];
    logic [2*W-1:0] held;

    always #5 clk = ~clk;

    man_mult_radix4 #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .ready_o        (ready_o),
        .signed_i       (signed_i),
        .multiplier_i   (multiplier_i),
        .multiplicand_i (multiplicand_i),
        .valid_o        (valid_o),
        .result_ready_i (result_ready_i),
        .product_low_o  (product_low_o),
        .product_high_o (product_high_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model_prod(input logic s, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        longint ea, eb, p;
        ea = s ? {{(64 - W){a[W-1]}}, a} : {{(64 - W){1'b0}}, a};
        eb = s ? {{(64 - W){b[W-1]}}, b} : {{(64 - W){1'b0}}, b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    function automatic int model_k(input logic s, input logic [W-1:0] b);
        logic [W+1:0] e, t, m;
        e = {{2{s & b[W-1]}}, b};
        for (int i = 0; i <= W / 2; i++) begin
            t = e >> (2 * i + 1);
            m = {(W + 2){1'b1}} >> (2 * i + 1);
            if (t == '0 || t == m || i == W / 2) return i + 1;
        end
        return W / 2 + 1;
    endfunction

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] p, input int k);
        int n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) check("ready_wait", 0, 1);
        start_i        = 1'b1;
        signed_i       = s;
        multiplier_i   = a;
        multiplicand_i = b;
        exp_q.push_back(p);
        lat_q.push_back(k + 1);
        @(negedge clk);
        start_i        = 1'b0;
        signed_i       = ~s;
        multiplier_i   = W'($urandom);
        multiplicand_i = W'($urandom);
    endtask

    task automatic wait_result();
        int             n = 0;
        int             lat;
        logic [2*W-1:0] p;
        while (!valid_o && n < 40) begin
            @(negedge clk);
            n++;
            multiplier_i   = W'($urandom);
            multiplicand_i = W'($urandom);
        end
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
            return;
        end
        p   = exp_q.pop_front();
        lat = lat_q.pop_front();
        check("latency", n, lat);
        check("ready_in_done", ready_o, 0);
        check("high", product_high_o, p[2*W-1:W]);
        check("low", product_low_o, p[W-1:0]);
        held = {product_high_o, product_low_o};
    endtask

    task automatic hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            result_ready_i = 1'b0;
            start_i        = 1'b1;
            multiplier_i   = W'($urandom);
            multiplicand_i = W'($urandom);
            @(negedge clk);
            check("hold_valid", valid_o, 1);
            check("hold_ready", ready_o, 0);
            check("hold_prod", {product_high_o, product_low_o}, held);
        end
        start_i = 1'b0;
    endtask

    task automatic release_result();
        result_ready_i = 1'b1;
        start_i        = 1'b0;
        @(negedge clk);
        result_ready_i = 1'b0;
        check("rel_valid", valid_o, 0);
        check("rel_ready", ready_o, 1);
        check("idle_prod", {product_high_o, product_low_o}, held);
    endtask

    initial begin
        logic         seen;
        logic         s;
        logic [W-1:0] a, b;

        reset_i        = 1'b1;
        start_i        = 1'b0;
        signed_i       = 1'b0;
        multiplier_i   = '0;
        multiplicand_i = '0;
        result_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_prod", {product_high_o, product_low_o}, 0);

        issue(1'b0, 28'd3, 28'd5, 56'd15, 2);
        wait_result();
        release_result();

        issue(1'b0, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE_0000001, 15);
        wait_result();
        release_result();

        issue(1'b1, 28'hFFFFFFF, 28'd7, 56'hFFFFFFF_FFFFFF9, 2);
        wait_result();
        release_result();

        issue(1'b1, 28'd9, 28'hFFFFFFF, 56'hFFFFFFF_FFFFFF7, 1);
        wait_result();
        release_result();

        issue(1'b0, 28'd12345, 28'd0, 56'd0, 1);
        wait_result();
        release_result();

        // Stalled consumer, then release with start_i still high.
        issue(1'b0, 28'd6, 28'd7, 56'd42, 2);
        wait_result();
        hold(5);
        result_ready_i = 1'b1;
        start_i        = 1'b1;
        signed_i       = 1'b0;
        multiplier_i   = 28'd3;
        multiplicand_i = 28'd5;
        exp_q.push_back(56'd15);
        lat_q.push_back(3);
        @(negedge clk);
        result_ready_i = 1'b0;
        check("b2b_idle_ready", ready_o, 1);
        check("b2b_idle_valid", valid_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        check("b2b_accepted", ready_o, 0);
        wait_result();
        release_result();

        // Reset in the third RUN cycle discards the operation.
        issue(1'b0, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE_0000001, 15);
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("midrst_ready", ready_o, 1);
        check("midrst_valid", valid_o, 0);
        check("midrst_prod", {product_high_o, product_low_o}, 0);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);
        issue(1'b0, 28'd3, 28'd5, 56'd15, 2);
        wait_result();
        release_result();

        for (int j = 0; j < 10; j++) begin
            s = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            if (j % 3 == 0) b = b >> $urandom_range(0, W - 1);
            issue(s, a, b, model_prod(s, a, b), model_k(s, b));
            wait_result();
            hold($urandom_range(0, 2));
            release_result();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
